// File: rtl/ysyx_22040125_mc_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer with handshake timeout and ebreak halt.
// Optional perf counters enabled by defining YSYX_22040125_CTRL_PERF_EN.
module ysyx_22040125_mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        ifu_req,
  input  logic        ifu_ack,
  input  logic [31:0] inst_in,
  output logic [31:0] inst_q,
  input  logic        dec_data_ren,
  input  logic        dec_data_wen,
  input  logic        dec_reg_wen,
  input  logic        dec_ebreak,
  output logic        lsu_req,
  output logic        lsu_we,
  input  logic        lsu_ack,
  output logic        rf_wen,
  output logic        pc_wen,
  output logic        halted,
`ifdef YSYX_22040125_CTRL_PERF_EN
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret,
`endif
  output logic        bus_err
);

  localparam logic [31:0]     INST_NOP = 32'h0000_0013;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

  typedef enum logic [7:0] {
    S_IDLE   = 8'b0000_0001,
    S_FETCH  = 8'b0000_0010,
    S_DECODE = 8'b0000_0100,
    S_EXEC   = 8'b0000_1000,
    S_MEM    = 8'b0001_0000,
    S_WB     = 8'b0010_0000,
    S_HALT   = 8'b0100_0000,
    S_ERR    = 8'b1000_0000
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TO_W-1:0] r_cnt;
  logic [TO_W-1:0] w_cnt_nxt;
  logic [TO_W-1:0] w_cnt_inc;
  logic            w_to_hit;
  logic            w_inst_load;
  logic            w_lsu_we_nxt;

  logic [31:0]     r_inst_q;
  logic            r_ifu_req;
  logic            r_lsu_req;
  logic            r_lsu_we;
  logic            r_rf_wen;
  logic            r_pc_wen;
  logic            r_halted;
  logic            r_bus_err;

  // Next-state, timeout counter and instruction-register load decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_inc    = r_cnt + TO_ONE;
    w_cnt_nxt    = r_cnt;
    w_to_hit     = (w_cnt_inc == TO_LIMIT);
    w_inst_load  = 1'b0;
    w_lsu_we_nxt = r_lsu_we;

    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (ifu_ack) begin
          w_state_nxt = S_DECODE;
          w_inst_load = 1'b1;
        end else if (w_to_hit) begin
          w_state_nxt = S_ERR;
        end
      end
      S_DECODE: begin
        w_state_nxt = dec_ebreak ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = (dec_data_ren | dec_data_wen) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (lsu_ack) w_state_nxt = S_WB;
        else if (w_to_hit) w_state_nxt = S_ERR;
      end
      S_WB:    w_state_nxt = S_FETCH;
      S_HALT:  w_state_nxt = S_HALT;
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase

    // Counter restarts on each entry into a request state, counts unanswered cycles.
    if ((w_state_nxt == S_FETCH && r_state != S_FETCH) ||
        (w_state_nxt == S_MEM   && r_state != S_MEM)) begin
      w_cnt_nxt = '0;
    end else if ((r_state == S_FETCH && !ifu_ack) ||
                 (r_state == S_MEM   && !lsu_ack)) begin
      w_cnt_nxt = w_cnt_inc;
    end

    // Store/load direction is latched on MEM entry so it stays stable until the ack.
    if (w_state_nxt != S_MEM) w_lsu_we_nxt = 1'b0;
    else if (r_state == S_EXEC) w_lsu_we_nxt = dec_data_wen;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output flops mirror the state being entered, so no ack reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst_q  <= INST_NOP;
      r_ifu_req <= 1'b0;
      r_lsu_req <= 1'b0;
      r_lsu_we  <= 1'b0;
      r_rf_wen  <= 1'b0;
      r_pc_wen  <= 1'b0;
      r_halted  <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_inst_load) r_inst_q <= inst_in;
      r_ifu_req <= (w_state_nxt == S_FETCH);
      r_lsu_req <= (w_state_nxt == S_MEM);
      r_lsu_we  <= w_lsu_we_nxt;
      r_rf_wen  <= (w_state_nxt == S_WB) & dec_reg_wen;
      r_pc_wen  <= (w_state_nxt == S_WB);
      r_halted  <= (w_state_nxt == S_HALT);
      r_bus_err <= (w_state_nxt == S_ERR);
    end
  end

`ifdef YSYX_22040125_CTRL_PERF_EN
  logic [63:0] r_perf_cycle;
  logic [63:0] r_perf_instret;
  logic        w_busy;
  logic        w_retire;

  assign w_busy   = !(r_state == S_IDLE || r_state == S_HALT || r_state == S_ERR);
  assign w_retire = (r_state == S_WB) || (r_state == S_DECODE && dec_ebreak);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cycle   <= '0;
      r_perf_instret <= '0;
    end else begin
      if (w_busy)   r_perf_cycle   <= r_perf_cycle + 64'd1;
      if (w_retire) r_perf_instret <= r_perf_instret + 64'd1;
    end
  end

  assign perf_cycle   = r_perf_cycle;
  assign perf_instret = r_perf_instret;
`endif

  assign inst_q  = r_inst_q;
  assign ifu_req = r_ifu_req;
  assign lsu_req = r_lsu_req;
  assign lsu_we  = r_lsu_we;
  assign rf_wen  = r_rf_wen;
  assign pc_wen  = r_pc_wen;
  assign halted  = r_halted;
  assign bus_err = r_bus_err;

endmodule

// File: doc/ysyx_22040125_mc_ctrl.md
Name: ysyx_22040125_mc_ctrl

Overview:
Multi-cycle sequencer for the single-issue RV64 core. Owns the instruction register that feeds the decoder and consumes the decoder's memory, writeback and ebreak controls. Steps each instruction through fetch, decode, execute, memory and writeback. Drives the instruction-fetch and load/store request handshakes, register-file and PC write strobes, halt on ebreak, and a bus-timeout error.

Parameters:
MEM_TIMEOUT, 255, max wait cycles for ifu_ack/lsu_ack before error (1..2^TO_W-1)
TO_W, 8, timeout counter width

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE and begin fetching
ifu_req  out  1  instruction fetch request
ifu_ack  in  1  fetch complete, inst_in valid this cycle
inst_in  in  32  fetched instruction word
inst_q  out  32  instruction register, drives decoder inst input
dec_data_ren  in  1  decoder: instruction is a load
dec_data_wen  in  1  decoder: instruction is a store
dec_reg_wen  in  1  decoder: instruction writes rd
dec_ebreak  in  1  decoder: instruction is ebreak
lsu_req  out  1  load/store request
lsu_we  out  1  1=store, 0=load, valid while lsu_req=1
lsu_ack  in  1  load/store complete
rf_wen  out  1  register-file write strobe, one cycle
pc_wen  out  1  PC update strobe, one cycle
halted  out  1  sticky, ebreak retired
bus_err  out  1  sticky, handshake timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE; inst_q=32'h00000013 (nop); timeout counter=0; all outputs 0. Reset mid-handshake drops ifu_req/lsu_req immediately; no completion is recorded.
- State encoding is one-hot. IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
- ifu_req, lsu_req, rf_wen, pc_wen, halted and bus_err are decoded from state flops only. They must not depend combinationally on any ack input.
- IDLE: all outputs 0. start=1 -> FETCH next cycle.
- FETCH: ifu_req=1. On ifu_ack=1: inst_q<=inst_in, -> DECODE. ifu_req is 0 in the cycle after the ack.
- DECODE: one cycle; decoder settles on inst_q.
  - dec_ebreak=1 -> HALT.
  - Otherwise -> EXEC.
- EXEC: one cycle (ALU).
  - dec_data_ren|dec_data_wen -> MEM.
  - Otherwise -> WB.
- MEM: lsu_req=1 and lsu_we=dec_data_wen; both held stable until ack. On lsu_ack=1 -> WB.
  - If both dec_data_ren and dec_data_wen are set, the access is a single store.
- WB: one cycle. pc_wen=1, rf_wen=dec_reg_wen. -> FETCH.
- HALT: halted=1; no requests. Terminal until reset; start is ignored.
- ERR: bus_err=1; no requests. Terminal until reset.
- Timeout counter:
  - Cleared on entry to FETCH and to MEM.
  - Increments each cycle in FETCH/MEM without an ack.
  - If it reaches MEM_TIMEOUT with no ack in that cycle -> ERR.
  - An ack in the same cycle the count reaches MEM_TIMEOUT wins (normal transition).
- An ack sampled outside its own request state is ignored.
- Latency with zero-wait ack (ack in first request cycle):
  - ALU/branch/jump: 4 cycles per instruction (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Each extra wait cycle adds 1.
- Store: rf_wen follows dec_reg_wen, which is 0 for stores.
- Inputs inst_in, dec_* are sampled only in the states listed above.

Optional Feature:
Macro YSYX_22040125_CTRL_PERF_EN.
- Defined: adds outputs perf_cycle[63:0] and perf_instret[63:0], both reset to 0 and wrapping at 2^64.
  - perf_cycle increments every cycle the state is not IDLE, HALT or ERR.
  - perf_instret increments in each WB cycle. The ebreak that enters HALT also counts once.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, start=1, inst_in=32'h00100093 (addi), ifu_ack in first FETCH cycle -> inst_q=32'h00100093 after ack; rf_wen=1 and pc_wen=1 exactly 4 cycles after FETCH entry; ifu_req reasserts next cycle.
- Load with dec_data_ren=1, lsu_ack delayed 3 cycles -> lsu_req high 4 cycles with lsu_we=0; WB 1 cycle after ack; total 8 cycles from FETCH entry.
- Store with dec_data_wen=1, dec_reg_wen=0 -> lsu_we=1 during MEM; WB with rf_wen=0 and pc_wen=1.
- inst_in=32'h00100073 with dec_ebreak=1 -> halted=1 two cycles after ack; no further ifu_req; start pulses ignored until rst_n low.
- MEM_TIMEOUT=4, ifu_ack held 0 -> bus_err=1 on the 5th cycle of FETCH, ifu_req=0. Repeat with ack on the count-4 cycle -> normal DECODE, bus_err=0.
- Assert rst_n=0 mid-MEM with lsu_req=1 -> lsu_req=0 and inst_q=32'h00000013 without a clock edge; with the macro defined, perf counters read 0.
